// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle shared by uart_tx_arbiter and its environment.
// master = arbiter side, slave = requesters plus transmitter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int DATA_WDTH = 8
);
    logic [N_REQ-1:0]           REQ_VALIDi;
    logic [N_REQ*DATA_WDTH-1:0] REQ_DATAi;
    logic [N_REQ-1:0]           REQ_LASTi;
    logic [N_REQ-1:0]           REQ_READYo;
    logic                       TX_READYi;
    logic                       TX_DONEi;
    logic                       TX_STARTo;
    logic [DATA_WDTH-1:0]       TX_DATAo;
    logic [N_REQ-1:0]           GRANTo;
    logic                       BUSYo;
    logic                       ERRo;

    modport master (
        input  REQ_VALIDi, REQ_DATAi, REQ_LASTi, TX_READYi, TX_DONEi,
        output REQ_READYo, TX_STARTo, TX_DATAo, GRANTo, BUSYo, ERRo
    );

    modport slave (
        output REQ_VALIDi, REQ_DATAi, REQ_LASTi, TX_READYi, TX_DONEi,
        input  REQ_READYo, TX_STARTo, TX_DATAo, GRANTo, BUSYo, ERRo
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte-stream requesters.
// A grant lasts one message (LAST byte or MAX_BURST bytes); each frame is supervised by a timeout.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_WDTH   = 8,
    parameter int MAX_BURST   = 16,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic              CLKip,
    input  logic              RSTi,
    uart_tx_arbiter_if.master bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [7:0]  BURST_LIM = 8'(MAX_BURST);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);
    localparam bit          TMO_EN    = (TIMEOUT_CYC != 0);

    logic [1:0]           state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     owner;
    logic [7:0]           burst_cnt;
    logic                 last_flag;
    logic [31:0]          tmr;
    logic                 tx_start;
    logic [DATA_WDTH-1:0] tx_data;
    logic                 err;

    logic [PTR_W-1:0]     sel_idx;
    logic                 sel_found;
    logic                 own_valid;
    logic                 own_last;
    logic [DATA_WDTH-1:0] own_data;
    logic                 xfer;
    logic [N_REQ-1:0]     ready;
    logic [N_REQ-1:0]     grant;

    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int ofs);
        rr_idx = PTR_W'((int'(base) + ofs) % N_REQ);
    endfunction

    // Search starts just after the last owner, so the releasing owner is tried last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_ptr;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!sel_found && bus.REQ_VALIDi[rr_idx(rr_ptr, i)]) begin
                sel_found = 1'b1;
                sel_idx   = rr_idx(rr_ptr, i);
            end
        end
    end

    assign own_valid = bus.REQ_VALIDi[owner];
    assign own_last  = bus.REQ_LASTi[owner];
    assign own_data  = bus.REQ_DATAi[owner*DATA_WDTH +: DATA_WDTH];
    assign xfer      = (state == ST_SEND) && own_valid && bus.TX_READYi;

    always_comb begin
        ready = '0;
        grant = '0;
        if (state == ST_SEND) ready[owner] = bus.TX_READYi;
        if (state != ST_IDLE) grant[owner] = 1'b1;
    end

    always_ff @(posedge CLKip) begin
        if (RSTi) begin
            state     <= ST_IDLE;
            rr_ptr    <= PTR_W'(N_REQ - 1);
            owner     <= '0;
            burst_cnt <= '0;
            last_flag <= 1'b0;
            tmr       <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            err       <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        owner     <= sel_idx;
                        burst_cnt <= '0;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (xfer) begin
                        tx_data   <= own_data;
                        tx_start  <= 1'b1;
                        last_flag <= own_last;
                        burst_cnt <= burst_cnt + 8'd1;
                        tmr       <= '0;
                        state     <= ST_WAIT;
                    end else if (!own_valid) begin
                        rr_ptr <= owner;
                        state  <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    tmr <= tmr + 32'd1;
                    // DONE is checked first so a coincident timeout never raises ERRo.
                    if (bus.TX_DONEi) begin
                        if (last_flag || (burst_cnt == BURST_LIM)) begin
                            rr_ptr <= owner;
                            state  <= ST_IDLE;
                        end else begin
                            state <= ST_SEND;
                        end
                    end else if (TMO_EN && (tmr == TMO_LAST)) begin
                        err    <= 1'b1;
                        rr_ptr <= owner;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.REQ_READYo = ready;
    assign bus.GRANTo     = grant;
    assign bus.TX_STARTo  = tx_start;
    assign bus.TX_DATAo   = tx_data;
    assign bus.BUSYo      = (state != ST_IDLE);
    assign bus.ERRo       = err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: dut_a (MAX_BURST=16, TIMEOUT_CYC=50) and dut_b (MAX_BURST=2).
// Each bus has a transmitter model that pulses TX_DONEi 10 clocks after each TX_STARTo.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N), .DATA_WDTH(DW)) bus_a ();
    uart_tx_arbiter_if #(.N_REQ(N), .DATA_WDTH(DW)) bus_b ();

    uart_tx_arbiter #(.N_REQ(N), .DATA_WDTH(DW), .MAX_BURST(16), .TIMEOUT_CYC(50)) dut_a (
        .CLKip(clk), .RSTi(rst_a), .bus(bus_a)
    );
    uart_tx_arbiter #(.N_REQ(N), .DATA_WDTH(DW), .MAX_BURST(2), .TIMEOUT_CYC(0)) dut_b (
        .CLKip(clk), .RSTi(rst_b), .bus(bus_b)
    );

    // Transmitter models: busy for 10 clocks after a start, DONE on the 10th.
    logic tx_busy_a = 1'b0, tx_done_mdl_a = 1'b0, tx_mute_a = 1'b0, tx_done_man_a = 1'b0;
    logic tx_busy_b = 1'b0, tx_done_mdl_b = 1'b0;
    int   tx_cnt_a = 0, tx_cnt_b = 0;

    always @(posedge clk) begin
        tx_done_mdl_a <= 1'b0;
        if (bus_a.TX_STARTo && !tx_mute_a) begin
            tx_busy_a <= 1'b1;
            tx_cnt_a  <= 1;
        end else if (tx_busy_a) begin
            tx_cnt_a <= tx_cnt_a + 1;
            if (tx_cnt_a == 9) begin
                tx_busy_a     <= 1'b0;
                tx_done_mdl_a <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        tx_done_mdl_b <= 1'b0;
        if (bus_b.TX_STARTo) begin
            tx_busy_b <= 1'b1;
            tx_cnt_b  <= 1;
        end else if (tx_busy_b) begin
            tx_cnt_b <= tx_cnt_b + 1;
            if (tx_cnt_b == 9) begin
                tx_busy_b     <= 1'b0;
                tx_done_mdl_b <= 1'b1;
            end
        end
    end

    assign bus_a.TX_READYi = !tx_busy_a;
    assign bus_a.TX_DONEi  = tx_done_mdl_a | tx_done_man_a;
    assign bus_b.TX_READYi = !tx_busy_b;
    assign bus_b.TX_DONEi  = tx_done_mdl_b;

    // Requester sources: per-requester byte FIFOs, {last, data}.
    logic [8:0]   mem_a [N][16];
    logic [8:0]   mem_b [N][16];
    int           hd_a[N], tl_a[N], hd_b[N], tl_b[N];
    logic [N-1:0] en_a, en_b;
    logic [N-1:0] acc_a, acc_b;

    always @(posedge clk) begin
        acc_a <= rst_a ? '0 : (bus_a.REQ_VALIDi & bus_a.REQ_READYo);
        acc_b <= rst_b ? '0 : (bus_b.REQ_VALIDi & bus_b.REQ_READYo);
    end

    int          n_run = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          st_cyc_a = 0;
    int          err_cyc_a = 0;
    int          err_n_a = 0;
    int          done_n_a = 0;
    logic [11:0] st_a[$];
    logic [11:0] st_b[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive_src();
        logic [8:0] ea;
        logic [8:0] eb;
        for (int k = 0; k < N; k++) begin
            ea = (hd_a[k] < tl_a[k]) ? mem_a[k][hd_a[k]] : 9'h0;
            eb = (hd_b[k] < tl_b[k]) ? mem_b[k][hd_b[k]] : 9'h0;
            bus_a.REQ_VALIDi[k]          = en_a[k] && (hd_a[k] < tl_a[k]);
            bus_a.REQ_DATAi[k*DW +: DW]  = ea[7:0];
            bus_a.REQ_LASTi[k]           = ea[8];
            bus_b.REQ_VALIDi[k]          = en_b[k] && (hd_b[k] < tl_b[k]);
            bus_b.REQ_DATAi[k*DW +: DW]  = eb[7:0];
            bus_b.REQ_LASTi[k]           = eb[8];
        end
    endtask

    task automatic clr_src();
        for (int k = 0; k < N; k++) begin
            hd_a[k] = 0; tl_a[k] = 0; hd_b[k] = 0; tl_b[k] = 0;
        end
        en_a = '0;
        en_b = '0;
        drive_src();
    endtask

    task automatic push_a(input int k, input logic [7:0] d, input logic last);
        mem_a[k][tl_a[k]] = {last, d};
        tl_a[k]++;
    endtask

    task automatic push_b(input int k, input logic [7:0] d, input logic last);
        mem_b[k][tl_b[k]] = {last, d};
        tl_b[k]++;
    endtask

    // One clock: sample outputs on the falling edge, retire accepted bytes, re-drive sources.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (acc_a[k]) hd_a[k]++;
            if (acc_b[k]) hd_b[k]++;
        end
        drive_src();
        if (bus_a.TX_STARTo) begin
            st_a.push_back({bus_a.GRANTo, bus_a.TX_DATAo});
            st_cyc_a = cyc;
        end
        if (bus_b.TX_STARTo) st_b.push_back({bus_b.GRANTo, bus_b.TX_DATAo});
        if (bus_a.ERRo) begin
            err_n_a++;
            err_cyc_a = cyc;
        end
        if (bus_a.TX_DONEi) done_n_a++;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        tick();
        tick();
        rst_a = 1'b0;
        st_a.delete();
        err_n_a  = 0;
        done_n_a = 0;
    endtask

    // Wait for n captured starts and then for the arbiter to go idle.
    task automatic wait_st(input bit on_b, input int n, input string tag);
        int t;
        t = 0;
        while (t < 3000 && (on_b ? (st_b.size() < n || bus_b.BUSYo)
                                 : (st_a.size() < n || bus_a.BUSYo))) begin
            tick();
            t++;
        end
        chk({tag, "_bound"}, (t < 3000), 1);
    endtask

    task automatic chk_st(input bit on_b, input int i, input logic [3:0] g, input logic [7:0] d,
                          input string tag);
        logic [11:0] act;
        act = 12'hfff;
        if (on_b) begin
            if (i < st_b.size()) act = st_b[i];
        end else begin
            if (i < st_a.size()) act = st_a[i];
        end
        chk(tag, act, {g, d});
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int cs;
        int gbad;

        rst_a = 1'b1;
        rst_b = 1'b1;
        clr_src();
        repeat (3) tick();

        // Reset state
        chk("rst_ready", bus_a.REQ_READYo, 0);
        chk("rst_start", bus_a.TX_STARTo, 0);
        chk("rst_data", bus_a.TX_DATAo, 0);
        chk("rst_grant", bus_a.GRANTo, 0);
        chk("rst_busy", bus_a.BUSYo, 0);
        chk("rst_err", bus_a.ERRo, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        st_a.delete();
        done_n_a = 0;

        // Single 3-byte message from requester 0
        push_a(0, 8'h55, 1'b0);
        push_a(0, 8'hAA, 1'b0);
        push_a(0, 8'h0F, 1'b1);
        en_a[0] = 1'b1;
        drive_src();
        tick();
        chk("t1_grant_lat", bus_a.GRANTo, 4'b0001);
        chk("t1_ready_same", bus_a.REQ_READYo, 4'b0001);
        tick();
        chk("t1_start_lat", bus_a.TX_STARTo, 1);
        chk("t1_data0", bus_a.TX_DATAo, 8'h55);
        gbad = 0;
        t = 0;
        while (done_n_a < 3 && t < 500) begin
            tick();
            if (bus_a.GRANTo != 4'b0001) gbad++;
            t++;
        end
        chk("t1_done_bound", (t < 500), 1);
        chk("t1_grant_held", gbad, 0);
        chk("t1_busy_at_done", bus_a.BUSYo, 1);
        tick();
        chk("t1_busy_after", bus_a.BUSYo, 0);
        chk("t1_grant_after", bus_a.GRANTo, 0);
        chk("t1_nstart", st_a.size(), 3);
        chk_st(1'b0, 0, 4'b0001, 8'h55, "t1_b0");
        chk_st(1'b0, 1, 4'b0001, 8'hAA, "t1_b1");
        chk_st(1'b0, 2, 4'b0001, 8'h0F, "t1_b2");

        // All four requesters with two single-byte messages each
        clr_src();
        reset_a();
        for (int k = 0; k < N; k++) begin
            push_a(k, 8'(8'h10 + k), 1'b1);
            push_a(k, 8'(8'h20 + k), 1'b1);
        end
        en_a = 4'b1111;
        drive_src();
        wait_st(1'b0, 8, "t2");
        chk("t2_nstart", st_a.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk_st(1'b0, i, 4'(1 << (i % 4)), 8'(((i < 4) ? 8'h10 : 8'h20) + (i % 4)), "t2_rr");
        end

        // MAX_BURST=2: long message from req2 interleaved with req3
        clr_src();
        push_b(2, 8'h21, 1'b0);
        push_b(2, 8'h22, 1'b0);
        push_b(2, 8'h23, 1'b0);
        push_b(2, 8'h24, 1'b0);
        push_b(2, 8'h25, 1'b1);
        push_b(3, 8'h31, 1'b1);
        en_b = 4'b1100;
        drive_src();
        wait_st(1'b1, 6, "t3");
        chk("t3_nstart", st_b.size(), 6);
        chk_st(1'b1, 0, 4'b0100, 8'h21, "t3_s0");
        chk_st(1'b1, 1, 4'b0100, 8'h22, "t3_s1");
        chk_st(1'b1, 2, 4'b1000, 8'h31, "t3_s2");
        chk_st(1'b1, 3, 4'b0100, 8'h23, "t3_s3");
        chk_st(1'b1, 4, 4'b0100, 8'h24, "t3_s4");
        chk_st(1'b1, 5, 4'b0100, 8'h25, "t3_s5");

        // Timeout: transmitter never answers
        clr_src();
        reset_a();
        tx_mute_a = 1'b1;
        push_a(1, 8'h41, 1'b1);
        push_a(2, 8'h42, 1'b1);
        en_a = 4'b0110;
        drive_src();
        t = 0;
        while (st_a.size() < 1 && t < 100) begin tick(); t++; end
        cs = st_cyc_a;
        t = 0;
        while (err_n_a < 1 && t < 100) begin tick(); t++; end
        chk("t4_err_seen", err_n_a, 1);
        chk("t4_err_delay", err_cyc_a - cs, 50);
        chk("t4_err_high", bus_a.ERRo, 1);
        chk("t4_grant_clr", bus_a.GRANTo, 0);
        tick();
        chk("t4_err_pulse", bus_a.ERRo, 0);
        chk("t4_next_grant", bus_a.GRANTo, 4'b0100);
        t = 0;
        while (err_n_a < 2 && t < 100) begin tick(); t++; end
        tx_mute_a = 1'b0;
        wait_st(1'b0, 2, "t4");
        chk("t4_nerr", err_n_a, 2);
        chk_st(1'b0, 0, 4'b0010, 8'h41, "t4_s0");
        chk_st(1'b0, 1, 4'b0100, 8'h42, "t4_s1");

        // Reset while req1 waits on a frame with two bytes pending
        clr_src();
        reset_a();
        push_a(1, 8'h51, 1'b0);
        push_a(1, 8'h52, 1'b0);
        push_a(1, 8'h53, 1'b1);
        en_a[1] = 1'b1;
        drive_src();
        t = 0;
        while (st_a.size() < 1 && t < 100) begin tick(); t++; end
        repeat (3) tick();
        chk("t5_in_wait", bus_a.GRANTo, 4'b0010);
        push_a(0, 8'h50, 1'b1);
        en_a[0] = 1'b1;
        rst_a = 1'b1;
        drive_src();
        tick();
        chk("t5_rst_ready", bus_a.REQ_READYo, 0);
        chk("t5_rst_start", bus_a.TX_STARTo, 0);
        chk("t5_rst_data", bus_a.TX_DATAo, 0);
        chk("t5_rst_grant", bus_a.GRANTo, 0);
        chk("t5_rst_busy", bus_a.BUSYo, 0);
        chk("t5_rst_err", bus_a.ERRo, 0);
        rst_a = 1'b0;
        st_a.delete();
        done_n_a = 0;
        tick();
        chk("t5_req0_first", bus_a.GRANTo, 4'b0001);
        t = 0;
        while (done_n_a < 1 && t < 100) begin tick(); t++; end
        chk("t5_stale_done_seen", done_n_a, 1);
        chk("t5_no_start_on_stale", st_a.size(), 0);
        wait_st(1'b0, 3, "t5");
        chk_st(1'b0, 0, 4'b0001, 8'h50, "t5_s0");
        chk_st(1'b0, 1, 4'b0010, 8'h52, "t5_s1");
        chk_st(1'b0, 2, 4'b0010, 8'h53, "t5_s2");

        // Owner drops valid between bytes
        clr_src();
        reset_a();
        push_a(2, 8'h61, 1'b0);
        push_a(2, 8'h62, 1'b0);
        push_a(2, 8'h63, 1'b1);
        push_a(3, 8'h71, 1'b1);
        en_a[2] = 1'b1;
        drive_src();
        t = 0;
        while (st_a.size() < 1 && t < 100) begin tick(); t++; end
        en_a[2] = 1'b0;
        drive_src();
        done_n_a = 0;
        t = 0;
        while (done_n_a < 1 && t < 100) begin tick(); t++; end
        chk("t6_drop_done", done_n_a, 1);
        tick();
        chk("t6_drop_send", bus_a.GRANTo, 4'b0100);
        tick();
        chk("t6_drop_idle", bus_a.BUSYo, 0);
        chk("t6_drop_grant", bus_a.GRANTo, 0);
        en_a = 4'b1100;
        drive_src();
        tick();
        chk("t6_rr_after_drop", bus_a.GRANTo, 4'b1000);
        wait_st(1'b0, 4, "t6a");
        chk_st(1'b0, 0, 4'b0100, 8'h61, "t6_s0");
        chk_st(1'b0, 1, 4'b1000, 8'h71, "t6_s1");
        chk_st(1'b0, 2, 4'b0100, 8'h62, "t6_s2");
        chk_st(1'b0, 3, 4'b0100, 8'h63, "t6_s3");

        // TX_DONEi on the very cycle the timeout would fire
        clr_src();
        reset_a();
        tx_mute_a = 1'b1;
        push_a(0, 8'h81, 1'b0);
        push_a(0, 8'h82, 1'b1);
        en_a[0] = 1'b1;
        drive_src();
        t = 0;
        while (st_a.size() < 1 && t < 100) begin tick(); t++; end
        cs = st_cyc_a;
        while (cyc < cs + 49) tick();
        tx_done_man_a = 1'b1;
        tick();
        tx_done_man_a = 1'b0;
        tx_mute_a     = 1'b0;
        chk("t6_coinc_no_err", bus_a.ERRo, 0);
        chk("t6_coinc_grant", bus_a.GRANTo, 4'b0001);
        wait_st(1'b0, 2, "t6b");
        chk("t6_coinc_nerr", err_n_a, 0);
        chk_st(1'b0, 1, 4'b0001, 8'h82, "t6_coinc_s1");

        // Stray TX_DONEi while idle
        chk("t6_stray_pre", bus_a.BUSYo, 0);
        tx_done_man_a = 1'b1;
        tick();
        tx_done_man_a = 1'b0;
        tick();
        chk("t6_stray_busy", bus_a.BUSYo, 0);
        chk("t6_stray_grant", bus_a.GRANTo, 0);
        chk("t6_stray_nstart", st_a.size(), 2);
        push_a(1, 8'h91, 1'b1);
        en_a[1] = 1'b1;
        drive_src();
        tick();
        chk("t6_post_grant", bus_a.GRANTo, 4'b0010);
        wait_st(1'b0, 3, "t6c");
        chk_st(1'b0, 2, 4'b0010, 8'h91, "t6_post_s");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
